seq_divider: RTL and testbench

- Multi-cycle restoring divider, parametrised in WIDTH, with run-time signed/unsigned mode.
- Accepts operands through a valid/ready input handshake and returns quotient/remainder through a valid/ready output handshake.
- Flags divide-by-zero and signed overflow.
- Drop-in arithmetic engine for datapaths that need a radix-2 divide with backpressure, one bit per cycle.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and out_ready; slave is the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned
// per operation, with valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ITER  | WIDTH shift/subtract steps, counter runs down to 1
// FIX   | sign correction (or zero-divisor result), outputs registered
// DONE  | result held with out_valid until out_ready
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic       clock,
  input logic       reset,
  seq_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;
  logic             ovf_pend;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             ovf_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             unused_rem_msb;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // The partial remainder never reaches the top bit once stored, so the shift drops it.
  assign shifted        = {rem[WIDTH-1:0], q[WIDTH-1]};
  assign trial          = shifted - {1'b0, dvs};
  assign unused_rem_msb = rem[WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      ovf_pend    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            rem        <= '0;
            dvs        <= mag(bus.divisor, bus.is_signed);
            sign_q     <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            sign_r     <= bus.is_signed & bus.dividend[WIDTH-1];
            ovf_pend   <= bus.is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                          && (bus.divisor == '1);
            if (bus.divisor == '0) begin
              // q carries the raw dividend through to the remainder output.
              zero_div <= 1'b1;
              q        <= bus.dividend;
              cnt      <= '0;
              state    <= FIX;
            end else begin
              zero_div <= 1'b0;
              q        <= mag(bus.dividend, bus.is_signed);
              cnt      <= CNT_W'(WIDTH);
              state    <= ITER;
            end
          end
        end
        ITER: begin
          if (!trial[WIDTH]) rem <= trial;
          else               rem <= shifted;
          q   <= {q[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            quotient_r  <= '1;
            remainder_r <= q;
            dbz_r       <= 1'b1;
            ovf_r       <= 1'b0;
          end else begin
            quotient_r  <= sign_q ? -q : q;
            remainder_r <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            dbz_r       <= 1'b0;
            ovf_r       <= ovf_pend;
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, random ops against an
// integer-arithmetic model, and hand-written backpressure/reset sequences.
module tb_seq_divider;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    logic         eovf;
    int           elat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eq, output logic [W-1:0] er,
                       output logic edbz, output logic eovf, output int elat);
    int sa, sb, min_v;
    min_v = -(1 << (W - 1));
    sa = sgn && a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = sgn && b[W-1] ? int'(b) - (1 << W) : int'(b);
    edbz = 1'b0; eovf = 1'b0; elat = W + 1;
    if (b == 0) begin
      eq = '1; er = a; edbz = 1'b1; elat = 1;
    end else if (sgn && sa == min_v && sb == -1) begin
      eq = W'(min_v); er = '0; eovf = 1'b1;
    end else begin
      eq = W'(sa / sb); er = W'(sa % sb);
    end
  endtask

  // Present operands, accept, count edges until out_valid; optionally release.
  task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit release_it, output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output logic ovf, output int lat);
    int guard;
    guard = 0;
    @(negedge clock);
    bus.in_valid = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
    while (!bus.in_ready && guard < 50) begin @(negedge clock); guard++; end
    chk("accept_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = W'($urandom); bus.divisor = W'($urandom); bus.is_signed = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clock); #1; lat++; end
    q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero; ovf = bus.overflow;
    if (release_it) begin
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic edbz, input logic eovf,
                           input int elat);
    logic [W-1:0] q, r;
    logic dbz, ovf;
    int lat;
    do_op(sgn, a, b, 1'b1, q, r, dbz, ovf, lat);
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " div_by_zero"}, dbz, edbz);
    chk({tag, " overflow"}, ovf, eovf);
    chk({tag, " latency"}, lat, elat);
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] q, r, eq, er, a, b, q0, r0;
    logic dbz, ovf, edbz, eovf, sgn;
    int lat, elat;

    vecs.push_back('{0, 8'd200, 8'd7,   8'd28,  8'd4,   0, 0, 9});
    vecs.push_back('{0, 8'd255, 8'd200, 8'd1,   8'd55,  0, 0, 9});
    vecs.push_back('{0, 8'd8,   8'd200, 8'd0,   8'd8,   0, 0, 9});
    vecs.push_back('{1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  0, 0, 9});
    vecs.push_back('{1, 8'h07,  8'hFE,  8'hFD,  8'h01,  0, 0, 9});
    vecs.push_back('{1, 8'h80,  8'hFF,  8'h80,  8'h00,  0, 1, 9});
    vecs.push_back('{0, 8'h55,  8'h00,  8'hFF,  8'h55,  1, 0, 1});
    vecs.push_back('{1, 8'h55,  8'h00,  8'hFF,  8'h55,  1, 0, 1});
    vecs.push_back('{0, 8'h80,  8'hFF,  8'h00,  8'h80,  0, 0, 9});
    vecs.push_back('{1, 8'h80,  8'h01,  8'h80,  8'h00,  0, 0, 9});

    bus.in_valid = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset flags", {bus.div_by_zero, bus.overflow}, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].eq,
                vecs[i].er, vecs[i].edbz, vecs[i].eovf, vecs[i].elat);

    for (int i = 0; i < 60; i++) begin
      sgn = 1'($urandom);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; end
      model(sgn, a, b, eq, er, edbz, eovf, elat);
      run_check($sformatf("rnd%0d %0d %0h/%0h", i, sgn, a, b), sgn, a, b, eq, er, edbz, eovf, elat);
    end

    // Backpressure: result held, new operands refused.
    do_op(1'b0, 8'd200, 8'd7, 1'b0, q0, r0, dbz, ovf, lat);
    chk("bp quotient", q0, 28);
    @(negedge clock);
    bus.in_valid = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("bp hold", {bus.out_valid, bus.in_ready, bus.quotient, bus.remainder},
          {1'b1, 1'b0, 8'd28, 8'd4});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
    chk("bp release", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("bp held after", {bus.quotient, bus.remainder}, {8'd28, 8'd4});
    repeat (3) begin @(negedge clock); chk("bp no stale accept", bus.in_ready, 1); end

    // Reset during the fourth iteration.
    @(negedge clock);
    bus.in_valid = 1'b1; bus.is_signed = 1'b0; bus.dividend = 8'd100; bus.divisor = 8'd3;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid reset state", {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder,
        bus.div_by_zero, bus.overflow}, {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0});
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("no result after reset", bus.out_valid, 0);
    end
    run_check("post reset 9/3", 1'b0, 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0, 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
